// File: rtl/gb_oam_dma_arbiter_if.sv
// Bus bundle for gb_oam_dma_arbiter: CPU side, external memory side, HRAM side and DMA status.
// The arbiter takes the slave modport; the CPU/memory environment takes the master modport.
interface gb_oam_dma_arbiter_if;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_wdata_i;
    logic        cpu_wr_i;
    logic [7:0]  cpu_rdata_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_wr_o;
    logic [7:0]  mem_rdata_i;
    logic [6:0]  hram_addr_o;
    logic [7:0]  hram_wdata_o;
    logic        hram_wr_o;
    logic [7:0]  hram_rdata_i;
    logic        dma_active_o;
    logic [7:0]  reg_dma_o;

    modport slave (
        input  cpu_addr_i, cpu_wdata_i, cpu_wr_i, mem_rdata_i, hram_rdata_i,
        output cpu_rdata_o, mem_addr_o, mem_wdata_o, mem_wr_o,
               hram_addr_o, hram_wdata_o, hram_wr_o, dma_active_o, reg_dma_o
    );

    modport master (
        output cpu_addr_i, cpu_wdata_i, cpu_wr_i, mem_rdata_i, hram_rdata_i,
        input  cpu_rdata_o, mem_addr_o, mem_wdata_o, mem_wr_o,
               hram_addr_o, hram_wdata_o, hram_wr_o, dma_active_o, reg_dma_o
    );
endinterface

// File: rtl/gb_oam_dma_arbiter.sv
// OAM DMA engine (FF46) and external bus arbiter; HRAM stays reachable by the CPU during DMA.
// Optional DMA_BUS_CONFLICT_EN: blocked CPU reads return the byte the engine is moving instead of FF.
module gb_oam_dma_arbiter #(
    parameter int unsigned DMA_LEN     = 160,
    parameter int unsigned START_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    gb_oam_dma_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RD, S_WR} state_t;

    localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [3:0] DELAY_LOAD = 4'((START_DELAY == 0) ? 0 : START_DELAY - 1);

    state_t      r_state;
    logic [7:0]  r_idx;
    logic [7:0]  r_src;
    logic [7:0]  r_latch;
    logic [7:0]  r_reg_dma;
    logic [3:0]  r_cnt;
    logic        r_active;

    logic        w_hram;
    logic        w_ff46;
    logic        w_ff46_wr;
    logic [15:0] w_mem_addr;
    logic [7:0]  w_mem_wdata;
    logic        w_mem_wr;
    logic        w_hram_wr;
    logic [7:0]  w_cpu_rdata;

    assign w_hram    = (bus.cpu_addr_i >= 16'hFF80) && (bus.cpu_addr_i != 16'hFFFF);
    assign w_ff46    = (bus.cpu_addr_i == 16'hFF46);
    assign w_ff46_wr = w_ff46 && bus.cpu_wr_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_src     <= '0;
            r_latch   <= '0;
            r_reg_dma <= '0;
            r_cnt     <= '0;
            r_active  <= 1'b0;
        end else begin
            if (r_state == S_RD)
                r_latch <= bus.mem_rdata_i;
            // An FF46 write preempts every other transition, including the final WR -> IDLE.
            if (w_ff46_wr) begin
                r_reg_dma <= bus.cpu_wdata_i;
                r_src     <= (bus.cpu_wdata_i >= 8'hE0) ? (bus.cpu_wdata_i & 8'hDF) : bus.cpu_wdata_i;
                r_idx     <= '0;
                r_cnt     <= DELAY_LOAD;
                if (START_DELAY == 0) begin
                    r_state  <= S_RD;
                    r_active <= 1'b1;
                end else begin
                    r_state  <= S_DELAY;
                    r_active <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: r_active <= 1'b0;
                    S_DELAY: begin
                        if (r_cnt == '0) begin
                            r_state  <= S_RD;
                            r_active <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    S_RD: begin
                        r_state  <= S_WR;
                        r_active <= 1'b1;
                    end
                    S_WR: begin
                        if (r_idx == LAST_IDX) begin
                            r_state  <= S_IDLE;
                            r_idx    <= '0;
                            r_active <= 1'b0;
                        end else begin
                            r_state  <= S_RD;
                            r_idx    <= r_idx + 8'd1;
                            r_active <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_mem_addr  = bus.cpu_addr_i;
        w_mem_wdata = bus.cpu_wdata_i;
        w_mem_wr    = bus.cpu_wr_i && !w_hram && !w_ff46;
        if (r_active) begin
            w_mem_wdata = r_latch;
            w_mem_wr    = (r_state == S_WR);
            w_mem_addr  = (r_state == S_RD) ? {r_src, r_idx} : (16'hFE00 + {8'h00, r_idx});
        end
        if (reset)
            w_mem_wr = 1'b0;
        w_hram_wr = bus.cpu_wr_i && w_hram && !reset;

        if (w_hram)
            w_cpu_rdata = bus.hram_rdata_i;
        else if (w_ff46)
            w_cpu_rdata = r_reg_dma;
        else if (r_active) begin
`ifdef DMA_BUS_CONFLICT_EN
            w_cpu_rdata = (r_state == S_RD) ? bus.mem_rdata_i : r_latch;
`else
            w_cpu_rdata = 8'hFF;
`endif
        end else
            w_cpu_rdata = bus.mem_rdata_i;
    end

    assign bus.mem_addr_o   = w_mem_addr;
    assign bus.mem_wdata_o  = w_mem_wdata;
    assign bus.mem_wr_o     = w_mem_wr;
    assign bus.hram_addr_o  = bus.cpu_addr_i[6:0];
    assign bus.hram_wdata_o = bus.cpu_wdata_i;
    assign bus.hram_wr_o    = w_hram_wr;
    assign bus.cpu_rdata_o  = w_cpu_rdata;
    assign bus.dma_active_o = r_active;
    assign bus.reg_dma_o    = r_reg_dma;

endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// Randomized bench for gb_oam_dma_arbiter: memory/HRAM models plus a cycle-schedule reference
// of the OAM DMA (active window, addresses, copied bytes, CPU visibility).
module tb_gb_oam_dma_arbiter;
    localparam int unsigned LEN = 160;
    localparam int unsigned SD  = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gb_oam_dma_arbiter_if bus ();

    gb_oam_dma_arbiter #(.DMA_LEN(LEN), .START_DELAY(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem  [0:65535];
    logic [7:0] hram [0:127];
    logic [7:0] hm   [0:126];

    assign bus.mem_rdata_i  = mem[bus.mem_addr_o];
    assign bus.hram_rdata_i = hram[bus.hram_addr_o];

    always @(posedge clk) begin
        if (bus.mem_wr_o)  mem[bus.mem_addr_o]   <= bus.mem_wdata_o;
        if (bus.hram_wr_o) hram[bus.hram_addr_o] <= bus.hram_wdata_o;
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        bus.cpu_addr_i  = a;
        bus.cpu_wdata_i = d;
        bus.cpu_wr_i    = w;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        drive(a, d, 1'b1);
        tick();
    endtask

    // Echo region E0..FF folds onto C0..DF.
    function automatic logic [7:0] src_page(input logic [7:0] v);
        return (v >= 8'hE0) ? v - 8'h20 : v;
    endfunction

    task automatic run_dma(input logic [7:0] v1, input logic pat, input int restart_at,
                           input logic [7:0] v2, input int reset_at);
        logic [7:0]  e1 [LEN];
        logic [7:0]  e2 [LEN];
        logic [7:0]  cur [LEN];
        logic [7:0]  pg, pg2, sent, regv, d, o, expd;
        logic [15:0] a, ea;
        logic [15:0] drop_a [$];
        logic [7:0]  drop_v [$];
        logic        exp_act, rdph, aborted;
        int          c, k, act, op, rs_at, nb;

        pg  = src_page(v1);
        pg2 = src_page(v2);
        for (int i = 0; i < int'(LEN); i++) begin
            e1[i] = pat ? (8'(i) ^ 8'hA5) : 8'($urandom);
            cpu_write({pg, 8'(i)}, e1[i]);
        end
        if (restart_at >= 0)
            for (int i = 0; i < int'(LEN); i++) begin
                e2[i] = 8'($urandom);
                cpu_write({pg2, 8'(i)}, e2[i]);
            end
        sent = 8'($urandom);
        for (int i = 0; i <= int'(LEN); i++)
            cpu_write(16'hFE00 + 16'(i), sent);

        cur = e1; regv = v1; rs_at = restart_at; aborted = 1'b0;
        drive(16'hFF46, v1, 1'b1);
        check("ff46_not_forwarded", bus.mem_wr_o, 1'b0);
        tick();

        c = 0; act = 0;
        while (c <= int'(SD + 2 * LEN)) begin
            exp_act = (c >= int'(SD)) && (c < int'(SD + 2 * LEN));
            k    = c - int'(SD);
            rdph = (k % 2) == 0;
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                check("rst_dma_active", bus.dma_active_o, 1'b0);
                check("rst_mem_wr", bus.mem_wr_o, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                tick();
                aborted = 1'b1;
                break;
            end
            if (c == rs_at) begin
                drive(16'hFF46, v2, 1'b1);
                check("restart_active", bus.dma_active_o, exp_act);
                check("restart_mem_wr", bus.mem_wr_o, exp_act && !rdph);
                tick();
                cur = e2; regv = v2; rs_at = -1; pg = pg2;
                c = 0; act = 0;
                continue;
            end
            op = int'($urandom_range(0, 4));
            if (!exp_act && op == 1) op = 0;
            case (op)
                1: begin
                    a = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
                    drop_a.push_back(a);
                    drop_v.push_back(mem[a]);
                    drive(a, 8'($urandom), 1'b1);
                end
                2: begin
                    o = 8'($urandom_range(0, 126));
                    d = 8'($urandom);
                    drive(16'hFF80 + 16'(o), d, 1'b1);
                    check("hram_wr_during", bus.hram_wr_o, 1'b1);
                    hm[o] = d;
                end
                3: begin
                    o = 8'($urandom_range(0, 126));
                    drive(16'hFF80 + 16'(o), 8'h00, 1'b0);
                    check("hram_rd_during", bus.cpu_rdata_o, hm[o]);
                end
                4: begin
                    drive(16'hFF46, 8'h00, 1'b0);
                    check("ff46_read", bus.cpu_rdata_o, regv);
                end
                default: begin
                    a = 16'($urandom_range(0, 16'hFEFF));
                    drive(a, 8'h00, 1'b0);
                    if (exp_act) begin
`ifdef DMA_BUS_CONFLICT_EN
                        expd = cur[k / 2];
`else
                        expd = 8'hFF;
`endif
                    end else
                        expd = mem[a];
                    check("cpu_read", bus.cpu_rdata_o, expd);
                end
            endcase
            check("dma_active", bus.dma_active_o, exp_act);
            if (bus.dma_active_o) act++;
            if (exp_act) begin
                ea = rdph ? {pg, 8'(k / 2)} : 16'hFE00 + 16'(k / 2);
                check("dma_addr", bus.mem_addr_o, ea);
                check("dma_mem_wr", bus.mem_wr_o, !rdph);
            end
            tick();
            c++;
        end

        nb = aborted ? (reset_at - int'(SD)) / 2 : int'(LEN);
        if (!aborted) check("active_cycles", 32'(act), 32'(2 * LEN));
        for (int i = 0; i < int'(LEN); i++)
            check("oam_byte", mem[16'hFE00 + 16'(i)], (i < nb) ? cur[i] : sent);
        check("oam_beyond", mem[16'hFE00 + 16'(LEN)], sent);
        check("reg_dma", bus.reg_dma_o, aborted ? 8'h00 : regv);
        foreach (drop_a[j])
            check("dropped_write", mem[drop_a[j]], drop_v[j]);
    endtask

    task automatic pass_through(input logic [15:0] a, input logic [7:0] d);
        drive(a, d, 1'b1);
        check("pt_mem_wr", bus.mem_wr_o, 1'b1);
        check("pt_mem_addr", bus.mem_addr_o, a);
        check("pt_mem_wdata", bus.mem_wdata_o, d);
        check("pt_active", bus.dma_active_o, 1'b0);
        tick();
        drive(a, 8'h00, 1'b0);
        check("pt_mem_wr_rd", bus.mem_wr_o, 1'b0);
        check("pt_read", bus.cpu_rdata_o, d);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        reset = 1'b1;
        drive(16'hC000, 8'h77, 1'b1);
        check("reset_mem_wr", bus.mem_wr_o, 1'b0);
        check("reset_active", bus.dma_active_o, 1'b0);
        check("reset_reg_dma", bus.reg_dma_o, 8'h00);
        drive(16'hFF90, 8'h11, 1'b1);
        check("reset_hram_wr", bus.hram_wr_o, 1'b0);
        reset = 1'b0;
        drive(16'h0000, 8'h00, 1'b0);
        tick();

        for (int o = 0; o < 127; o++) begin
            d = 8'($urandom);
            drive(16'hFF80 + 16'(o), d, 1'b1);
            check("hram_init_memwr", bus.mem_wr_o, 1'b0);
            hm[o] = d;
            tick();
        end

        pass_through(16'hC123, 8'h5A);
        for (int i = 0; i < 6; i++)
            pass_through(16'($urandom_range(16'hC000, 16'hDFFF)), 8'($urandom));

        run_dma(8'hC0, 1'b1, -1, 8'h00, -1);
        run_dma(8'hE1, 1'b0, -1, 8'h00, -1);
        run_dma(8'hC8, 1'b0, int'(SD + 2 * 50), 8'hD0, -1);
        run_dma(8'hCA, 1'b0, int'(SD + 2 * LEN - 1), 8'hE3, -1);
        run_dma(8'hC4, 1'b0, -1, 8'h00, int'(SD + 2 * 10));
        pass_through(16'hC123, 8'hA7);
        for (int i = 0; i < 2; i++)
            run_dma(8'($urandom_range(8'hC0, 8'hFD)), 1'b0, -1, 8'h00, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
